// File: rtl/int_bridge.sv
// int_bridge: command FIFO plus single-outstanding request/grant memory issuer.
// Commands from ingress are queued, issued one at a time with lane-positioned
// write data and byte enables, and read data is returned LSB-aligned with a
// one-cycle int_read_done strobe.
//
// Optional build macro: INT_BRIDGE_ALIGN_CHK_EN adds align_err and suppresses
// memory access for misaligned half/word commands.
//
// Ports:
//   clk, rstN                 clock, asynchronous active-low reset
//   int_valid, int_addr_data  command strobe and {addr, LSB-aligned wdata}
//   int_size, current_read_write  size code and read(1)/write(0) flag
//   int_ready                 at least two free FIFO entries
//   int2ig_data, int_read_done    read return data and its valid strobe
//   new_tran                  pulse when a command is popped for issue
//   mem_*                     request/grant memory port
//   align_err                 (macro only) misaligned command pulse
module int_bridge #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 7
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          int_valid,
  input  logic [AW+31:0] int_addr_data,
  input  logic [1:0]    int_size,
  input  logic          current_read_write,
  output logic          int_ready,
  output logic [31:0]   int2ig_data,
  output logic          new_tran,
  output logic          int_read_done,
`ifdef INT_BRIDGE_ALIGN_CHK_EN
  output logic          align_err,
`endif
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned EntW = AW + 35;
  localparam logic [PtrW:0] DepthC   = (PtrW+1)'(DEPTH);
  localparam logic [PtrW:0] ReadyMax = (PtrW+1)'(DEPTH - 2);

  typedef enum logic [1:0] {StIdle, StIssue, StRdWait, StRdDone} state_e;

  // Command FIFO
  logic [EntW-1:0] fifo_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            push, pop;

  state_e          state_q;

  assign push = int_valid && (count_q != DepthC);
  assign pop  = (state_q == StIdle) && (count_q != '0);
  // One spare slot absorbs the strobe that lags ingress's handshake by a cycle.
  assign int_ready = (count_q <= ReadyMax);

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {current_read_write, int_size, int_addr_data};
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  // Head-of-queue decode and lane mapping
  logic          h_rw;
  logic [1:0]    h_size;
  logic [AW-1:0] h_addr;
  logic [31:0]   h_wdata;
  logic [1:0]    h_off;
  logic          h_byte, h_half;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;

  assign {h_rw, h_size, h_addr, h_wdata} = fifo_q[rd_ptr_q];
  assign h_off  = h_addr[1:0];
  assign h_byte = (h_size == 2'b01);
  assign h_half = (h_size == 2'b10);

  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = h_wdata;
    if (h_byte) begin
      lane_be    = 4'b0001 << h_off;
      lane_wdata = h_wdata << {h_off, 3'b000};
    end else if (h_half) begin
      // A half at offset 3 deliberately loses its upper byte.
      lane_be    = 4'b0011 << h_off;
      lane_wdata = h_wdata << {h_off, 3'b000};
    end
  end

`ifdef INT_BRIDGE_ALIGN_CHK_EN
  logic h_misalign;
  logic align_err_q;
  assign h_misalign = h_half ? h_off[0] : (!h_byte && (h_off != 2'b00));
  assign align_err  = align_err_q;
`endif

  // Command register and read-return extraction
  logic          cmd_rw_q;
  logic [1:0]    cmd_size_q;
  logic [1:0]    cmd_off_q;
  logic [31:0]   rd_shift, rd_ext;

  assign rd_shift = mem_rdata >> {cmd_off_q, 3'b000};

  always_comb begin
    rd_ext = mem_rdata;
    case (cmd_size_q)
      2'b01:   rd_ext = {24'h0, rd_shift[7:0]};
      2'b10:   rd_ext = {16'h0, rd_shift[15:0]};
      default: rd_ext = mem_rdata;
    endcase
  end

  // Issue FSM with registered outputs
  logic          new_tran_q, done_q, req_q, we_q;
  logic [31:0]   rdata_q, wdata_q;
  logic [AW-1:0] addr_q;
  logic [3:0]    be_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= StIdle;
      cmd_rw_q    <= 1'b0;
      cmd_size_q  <= 2'b00;
      cmd_off_q   <= 2'b00;
      new_tran_q  <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
`ifdef INT_BRIDGE_ALIGN_CHK_EN
      align_err_q <= 1'b0;
`endif
    end else begin
      new_tran_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef INT_BRIDGE_ALIGN_CHK_EN
      align_err_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            new_tran_q <= 1'b1;
            cmd_rw_q   <= h_rw;
            cmd_size_q <= h_size;
            cmd_off_q  <= h_off;
            we_q       <= !h_rw;
            addr_q     <= {h_addr[AW-1:2], 2'b00};
            be_q       <= lane_be;
            wdata_q    <= lane_wdata;
`ifdef INT_BRIDGE_ALIGN_CHK_EN
            if (h_misalign) begin
              // Never touches memory; a read still completes with a marker value.
              align_err_q <= 1'b1;
              if (h_rw) begin
                rdata_q <= 32'hDEAD_BEEF;
                done_q  <= 1'b1;
                state_q <= StRdDone;
              end
            end else begin
              req_q   <= 1'b1;
              state_q <= StIssue;
            end
`else
            req_q   <= 1'b1;
            state_q <= StIssue;
`endif
          end
        end
        StIssue: begin
          if (mem_gnt) begin
            req_q   <= 1'b0;
            state_q <= cmd_rw_q ? StRdWait : StIdle;
          end
        end
        StRdWait: begin
          if (mem_rvalid) begin
            rdata_q <= rd_ext;
            done_q  <= 1'b1;
            state_q <= StRdDone;
          end
        end
        StRdDone: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign new_tran      = new_tran_q;
  assign int_read_done = done_q;
  assign int2ig_data   = rdata_q;
  assign mem_req       = req_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_be        = be_q;
  assign mem_wdata     = wdata_q;

endmodule

// File: tb/tb_int_bridge.sv
// Self-checking bench for int_bridge: directed vector table, multi-cycle
// sequences (backpressure, pointer wrap, async reset) and randomized commands
// checked against a byte-lane reference model.
module tb_int_bridge;
  localparam int unsigned DEPTH = 4;

  logic        clk, rstN, int_valid, current_read_write;
  logic [38:0] int_addr_data;
  logic [1:0]  int_size;
  logic        int_ready, new_tran, int_read_done;
  logic [31:0] int2ig_data;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [6:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef INT_BRIDGE_ALIGN_CHK_EN
  logic        align_err;
`endif

  int checks, errors, case_id;

  int_bridge #(.DEPTH(DEPTH), .AW(7)) dut (
    .clk                (clk),
    .rstN               (rstN),
    .int_valid          (int_valid),
    .int_addr_data      (int_addr_data),
    .int_size           (int_size),
    .current_read_write (current_read_write),
    .int_ready          (int_ready),
    .int2ig_data        (int2ig_data),
    .new_tran           (new_tran),
    .int_read_done      (int_read_done),
`ifdef INT_BRIDGE_ALIGN_CHK_EN
    .align_err          (align_err),
`endif
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_be             (mem_be),
    .mem_wdata          (mem_wdata),
    .mem_gnt            (mem_gnt),
    .mem_rvalid         (mem_rvalid),
    .mem_rdata          (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [6:0]  maddr;
    logic [31:0] mwdata;
    logic [31:0] rd;
  } vec_t;

  vec_t       tbl[$];
  logic [6:0] q_addr[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (case %0d): got %h expected %h", what, case_id, act, exp);
    end
  endtask

  task automatic fail(input string what);
    checks++;
    errors++;
    $display("FAIL %s (case %0d): bound expired or condition violated", what, case_id);
  endtask

  function automatic vec_t mk(input logic rw, input logic [1:0] sz, input logic [6:0] a,
                              input logic [31:0] wd, input logic [31:0] rdat,
                              input logic [3:0] be, input logic [6:0] ma,
                              input logic [31:0] mw, input logic [31:0] rd);
    vec_t v;
    v.rw = rw; v.size = sz; v.addr = a; v.wdata = wd; v.rdata = rdat;
    v.be = be; v.maddr = ma; v.mwdata = mw; v.rd = rd;
    return v;
  endfunction

  // Reference model: view the 32-bit bus as four byte lanes.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int n, off;
    r = v;
    n = (v.size == 2'b01) ? 1 : (v.size == 2'b10) ? 2 : 4;
    off = (n == 4) ? 0 : int'(v.addr[1:0]);
    r.maddr = v.addr & 7'h7C;
    r.be = '0; r.mwdata = '0; r.rd = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + n) r.be[i] = 1'b1;
      if (i >= off) r.mwdata[8*i +: 8] = v.wdata[8*(i-off) +: 8];
    end
    for (int j = 0; j < n; j++)
      if (off + j < 4) r.rd[8*j +: 8] = v.rdata[8*(off+j) +: 8];
    return r;
  endfunction

  task automatic push(input logic rw, input logic [1:0] sz, input logic [6:0] a,
                      input logic [31:0] wd);
    int_valid = 1'b1; current_read_write = rw; int_size = sz; int_addr_data = {a, wd};
    tick();
    int_valid = 1'b0;
  endtask

  // Full transaction on an idle bridge; gd = grant delay, rd = rvalid delay.
  task automatic run_cmd(input vec_t v, input int gd, input int rd);
    int n;
    push(v.rw, v.size, v.addr, v.wdata);
    n = 0;
    while (!mem_req && n < 20) begin tick(); n++; end
    if (!mem_req) begin fail("req_timeout"); return; end
    chk("new_tran", new_tran, 1);
    chk("mem_we", mem_we, !v.rw);
    chk("mem_addr", mem_addr, v.maddr);
    chk("mem_be", mem_be, v.be);
    chk("mem_wdata", mem_wdata, v.mwdata);
    for (int i = 0; i < gd; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;  // must be ignored while issuing
      tick();
      chk("req_hold", mem_req, 1);
      chk("new_tran_pulse", new_tran, 0);
      chk("addr_hold", mem_addr, v.maddr);
      chk("wdata_hold", mem_wdata, v.mwdata);
    end
    mem_rvalid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("req_drop", mem_req, 0);
    if (v.rw) begin
      for (int i = 0; i < rd; i++) begin
        chk("done_early", int_read_done, 0);
        tick();
      end
      mem_rvalid = 1'b1; mem_rdata = v.rdata;
      tick();
      mem_rvalid = 1'b0;
      chk("read_done", int_read_done, 1);
      chk("rdata", int2ig_data, v.rd);
      tick();
      chk("read_done_pulse", int_read_done, 0);
      chk("rdata_hold", int2ig_data, v.rd);
    end else begin
      chk("wr_no_done", int_read_done, 0);
    end
  endtask

  vec_t v;
  int   pushes, pops, k;
  bit   pushed, s_err, s_req, s_done, s_nt;
  logic [31:0] s_data;

  initial begin
    checks = 0; errors = 0; case_id = 0;
    rstN = 1'b0; int_valid = 1'b0; current_read_write = 1'b0; int_size = 2'b00;
    int_addr_data = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_req", mem_req, 0);
    chk("rst_new_tran", new_tran, 0);
    chk("rst_done", int_read_done, 0);
    chk("rst_data", int2ig_data, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_ready_empty", int_ready, 1);
`ifdef INT_BRIDGE_ALIGN_CHK_EN
    chk("rst_align_err", align_err, 0);
`endif
    rstN = 1'b1;
    tick();

    // Directed vector table
    tbl.push_back(mk(0, 2'b01, 7'h05, 32'h0000_00A5, 0, 4'b0010, 7'h04, 32'h0000_A500, 0));
    tbl.push_back(mk(1, 2'b10, 7'h0A, 0, 32'h1234_5678, 4'b1100, 7'h08, 0, 32'h0000_1234));
    tbl.push_back(mk(0, 2'b00, 7'h10, 32'h1122_3344, 0, 4'b1111, 7'h10, 32'h1122_3344, 0));
    tbl.push_back(mk(1, 2'b01, 7'h7F, 0, 32'hAABB_CCDD, 4'b1000, 7'h7C, 0, 32'h0000_00AA));
    tbl.push_back(mk(0, 2'b10, 7'h22, 32'h0000_BEEF, 0, 4'b1100, 7'h20, 32'hBEEF_0000, 0));
    tbl.push_back(mk(1, 2'b00, 7'h44, 0, 32'hCAFE_F00D, 4'b1111, 7'h44, 0, 32'hCAFE_F00D));
    tbl.push_back(mk(0, 2'b11, 7'h08, 32'h55AA_55AA, 0, 4'b1111, 7'h08, 32'h55AA_55AA, 0));
    tbl.push_back(mk(0, 2'b01, 7'h02, 32'h1234_56FF, 0, 4'b0100, 7'h00, 32'h56FF_0000, 0));
    tbl.push_back(mk(1, 2'b01, 7'h01, 0, 32'h1122_3344, 4'b0010, 7'h00, 0, 32'h0000_0033));
`ifndef INT_BRIDGE_ALIGN_CHK_EN
    tbl.push_back(mk(0, 2'b10, 7'h0B, 32'h0000_ABCD, 0, 4'b1000, 7'h08, 32'hCD00_0000, 0));
    tbl.push_back(mk(1, 2'b00, 7'h45, 0, 32'h89AB_CDEF, 4'b1111, 7'h44, 0, 32'h89AB_CDEF));
    tbl.push_back(mk(1, 2'b10, 7'h0F, 0, 32'h89AB_CDEF, 4'b1000, 7'h0C, 0, 32'h0000_0089));
`endif
    foreach (tbl[i]) begin
      case_id = i + 1;
      run_cmd(tbl[i], i % 3, (i == 1) ? 1 : i % 3);
      tick();
    end

    // Backpressure: one write stuck awaiting grant, then three more queued
    case_id = 100;
    mem_gnt = 1'b0;
    push(0, 2'b00, 7'h00, 32'h0);
    tick();
    chk("bp_c0_req", mem_req, 1);
    push(0, 2'b00, 7'h04, 32'h1);
    chk("bp_ready1", int_ready, 1);
    push(0, 2'b00, 7'h08, 32'h2);
    chk("bp_ready2", int_ready, 1);
    push(0, 2'b00, 7'h0C, 32'h3);
    chk("bp_ready_low", int_ready, 0);
    q_addr.delete();
    q_addr.push_back(mem_addr);
    mem_gnt = 1'b1;
    tick();
    chk("bp_ready_still_low", int_ready, 0);
    chk("bp_req_gap", mem_req, 0);
    tick();
    chk("bp_pop", new_tran, 1);
    chk("bp_ready_rise", int_ready, 1);
    for (int c = 0; c < 12; c++) begin
      if (mem_req) q_addr.push_back(mem_addr);
      tick();
    end
    mem_gnt = 1'b0;
    chk("bp_count", q_addr.size(), 4);
    if (q_addr.size() == 4)
      for (int i = 0; i < 4; i++) chk("bp_order", q_addr[i], 7'(4 * i));

    // Streaming across the pointer wrap with grant always high
    case_id = 200;
    q_addr.delete(); pushes = 0; pops = 0; k = 0;
    mem_gnt = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (k < DEPTH + 2 && int_ready) begin
        int_valid = 1'b1; current_read_write = 1'b0; int_size = 2'b00;
        int_addr_data = {7'h40 + 7'(4 * k), 32'(k)};
        k++; pushed = 1'b1;
      end else begin
        int_valid = 1'b0; pushed = 1'b0;
      end
      tick();
      if (pushed) pushes++;
      if (new_tran) pops++;
      if (mem_req) q_addr.push_back(mem_addr);
      chk("wrap_ready", int_ready, ((pushes - pops) <= DEPTH - 2));
      if ((pushes - pops) > DEPTH - 1) fail("wrap_occupancy");
    end
    int_valid = 1'b0; mem_gnt = 1'b0;
    chk("wrap_count", q_addr.size(), DEPTH + 2);
    if (q_addr.size() == DEPTH + 2)
      for (int i = 0; i < DEPTH + 2; i++) chk("wrap_order", q_addr[i], 7'h40 + 7'(4 * i));

    // Randomized commands against the lane model
    for (int i = 0; i < 40; i++) begin
      case_id = 300 + i;
      v.rw = 1'($urandom_range(0, 1));
      v.size = 2'($urandom_range(0, 3));
      v.addr = 7'($urandom);
      v.wdata = $urandom;
      v.rdata = $urandom;
`ifdef INT_BRIDGE_ALIGN_CHK_EN
      if (v.size == 2'b10) v.addr[0] = 1'b0;
      else if (v.size != 2'b01) v.addr[1:0] = 2'b00;
`endif
      run_cmd(model(v), $urandom_range(0, 3), $urandom_range(0, 3));
      tick();
    end

`ifdef INT_BRIDGE_ALIGN_CHK_EN
    // Misaligned word read and half write
    case_id = 400;
    push(1, 2'b00, 7'h02, 32'h0);
    s_err = 0; s_req = 0; s_done = 0; s_nt = 0; s_data = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (align_err) s_err = 1;
      if (mem_req) s_req = 1;
      if (new_tran) s_nt = 1;
      if (int_read_done) begin s_done = 1; s_data = int2ig_data; end
    end
    chk("al_rd_err", s_err, 1);
    chk("al_rd_no_req", s_req, 0);
    chk("al_rd_new_tran", s_nt, 1);
    chk("al_rd_done", s_done, 1);
    chk("al_rd_data", s_data, 32'hDEAD_BEEF);
    case_id = 401;
    push(0, 2'b10, 7'h01, 32'h1234);
    s_err = 0; s_req = 0; s_done = 0; s_nt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (align_err) s_err = 1;
      if (mem_req) s_req = 1;
      if (new_tran) s_nt = 1;
      if (int_read_done) s_done = 1;
    end
    chk("al_wr_err", s_err, 1);
    chk("al_wr_no_req", s_req, 0);
    chk("al_wr_new_tran", s_nt, 1);
    chk("al_wr_no_done", s_done, 0);
`endif

    // Asynchronous reset while waiting for read data, with a command queued
    case_id = 500;
    push(1, 2'b00, 7'h30, 32'h0);
    push(0, 2'b00, 7'h34, 32'h77);
    chk("rst_seq_req", mem_req, 1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #2 rstN = 1'b0;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_we", mem_we, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_be", mem_be, 0);
    chk("arst_wdata", mem_wdata, 0);
    chk("arst_new_tran", new_tran, 0);
    chk("arst_done", int_read_done, 0);
    chk("arst_data", int2ig_data, 0);
    chk("arst_fifo_empty", int_ready, 1);
    tick();
    tick();
    rstN = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
    tick();
    mem_rvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("post_rst_done", int_read_done, 0);
      chk("post_rst_req", mem_req, 0);
      chk("post_rst_new_tran", new_tran, 0);
      tick();
    end
    chk("post_rst_data", int2ig_data, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
